maxnet_winner_engine: RTL and testbench
=======================================

// Module: maxnet_winner_engine
// PURPOSE
//  Parametrised MaxNet winner-take-all engine: N channels, W-bit activations.
//  Captures an input vector and iterates lateral inhibition until exactly one channel is non-zero.
//  Reports the winner's index and its original input value.
//  Unlike the fixed 4-channel datapath, it owns its FSM, start/done handshake, tie detection and an iteration cap.
//  Sits between the feature memory and the classifier result register.
// PARAMETERS
//  N          4   number of channels (>=2)
//  W          32  activation width, signed two's complement integer
//  EPS_SHIFT  3   inhibition weight eps = 2^-EPS_SHIFT; require 2^EPS_SHIFT >= N
//  MAX_ITER   64  iteration cap before timeout (>=1)
// PORTS
//  clk         in   1                  rising-edge clock
//  rst         in   1                  synchronous, active-high reset
//  start       in   1                  request; sampled only in IDLE
//  x_in        in   N*W                channel i = x_in[i*W +: W]
//  busy        out  1                  high in CHECK/UPDATE/DONE
//  done        out  1                  one-cycle pulse at completion
//  valid       out  1                  exactly one survivor found
//  timeout     out  1                  MAX_ITER reached without a single survivor
//  winner_idx  out  $clog2(N)          index of survivor
//  res         out  W                  captured x_in of survivor
//  iter_count  out  $clog2(MAX_ITER+1) updates performed
// BEHAVIOUR
//  Reset (rst=1 at an edge, any state, takes priority over everything else):
//   - state=IDLE
//   - all outputs 0, internal x_reg/a_reg/iter cleared
//  State IDLE:
//   - start=1 -> x_reg <= x_in; a_reg[i] <= max(x_in[i],0); iter <= 0
//   - clear valid/timeout/winner_idx/res; go to CHECK
//  State CHECK: count nonzero a_reg[i], giving nz.
//   - nz==1        -> valid<=1; winner_idx<=that i; res<=x_reg[i]
//   - nz==0        -> valid<=0 (tie/all non-positive)
//   - iter==MAX_ITER -> timeout<=1
//   - else -> UPDATE
//   - Priority: nz==1 > nz==0 > timeout. The first three branches go to DONE.
//  State UPDATE:
//   - S = sum a_reg, computed at W+$clog2(N) bits
//   - a_reg[i] <= max(a_reg[i] - ((S - a_reg[i]) >>> EPS_SHIFT), 0); all channels update at the same edge
//   - iter <= iter+1; go to CHECK
//  State DONE: done=1 for this cycle only; go to IDLE.
//  Outputs after DONE:
//   - valid/timeout/winner_idx/res/iter_count hold until the next accepted start or rst
//   - iter_count mirrors iter
//  Handshake: start ignored while busy; start in the same cycle as DONE is ignored, so it must be re-asserted in IDLE.
//  Latency:
//   - done is high in the cycle 2+2*I edges after the start edge, where I = iter_count
//   - with a single survivor at capture, I=0 and done comes 2 cycles after start
//  Arithmetic:
//   - activations stay >= 0 after capture, so the shift acts on non-negative values
//   - no overflow is possible within W+$clog2(N) bits
//  Timing: all outputs registered; no combinational path from x_in/start to outputs.
// TESTING (N=4, W=32, EPS_SHIFT=3, MAX_ITER=64)
//  1 x=[0,50,0,0], start -> done 2 cycles later; valid=1, winner_idx=1, res=50, iter_count=0.
//  2 x=[80,40,0,0] -> first update a=[75,30,0,0]; ends with valid=1, winner_idx=0, res=80, timeout=0.
//  3 x=[16,16,16,16] -> a stalls at [2,2,2,2]; done at cycle 130: valid=0, timeout=1, iter_count=64.
//  4 x=[-5,0,-1,0] -> clamped to all-zero; done 2 cycles later with valid=0, timeout=0, iter_count=0.
//  5 start pulsed while busy on case 2 -> ignored; result identical to case 2. Second start in IDLE -> fresh run.
//  6 rst asserted during UPDATE of case 2 -> next cycle busy=0, all outputs 0; a new start runs case 1 correctly.

Source files
------------

// File: rtl/maxnet_winner_engine.sv
// -----------------------------------------------------------------------------
// maxnet_winner_engine
//
// Purpose:
//   MaxNet winner-take-all engine for N channels of W-bit signed activations.
//   On start it captures the input vector and clamps negatives to zero. It then
//   repeats lateral inhibition until one channel is non-zero, no channel is
//   non-zero, or MAX_ITER updates have been performed. It reports the winner's
//   index together with the value that channel had at capture.
//
// Handshake:
//   start is sampled only in IDLE. Any start seen while busy is ignored.
//   done is a one-cycle pulse, visible 2+2*iter_count edges after the start
//   edge. valid/timeout/winner_idx/res/iter_count then hold until the next
//   accepted start or reset.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   run request (IDLE only)
//   x_in        in   packed inputs, channel i = x_in[i*W +: W]
//   busy        out  high while in CHECK/UPDATE/DONE
//   done        out  one-cycle completion pulse
//   valid       out  exactly one survivor found
//   timeout     out  iteration cap reached without a single survivor
//   winner_idx  out  index of the survivor
//   res         out  captured input value of the survivor
//   iter_count  out  number of inhibition updates performed
//   dbg_state   out  current FSM state encoding
// -----------------------------------------------------------------------------
module maxnet_winner_engine #(
    parameter int N         = 4,
    parameter int W         = 32,
    parameter int EPS_SHIFT = 3,
    parameter int MAX_ITER  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [N*W-1:0]                x_in,
    output logic                          busy,
    output logic                          done,
    output logic                          valid,
    output logic                          timeout,
    output logic [$clog2(N)-1:0]          winner_idx,
    output logic [W-1:0]                  res,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count,
    output logic [1:0]                    dbg_state
);

    localparam int IDXW = $clog2(N);
    localparam int IW   = $clog2(MAX_ITER + 1);
    localparam int SW   = W + $clog2(N);
    localparam int NZW  = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_x [N];
    logic [W-1:0]    r_a [N];
    logic [IW-1:0]   r_iter;

    logic [NZW-1:0]         w_nz_cnt;
    logic [IDXW-1:0]        w_win_idx;
    logic signed [SW-1:0]   w_sum;
    logic signed [SW-1:0]   w_diff [N];
    logic [W-1:0]           w_a_next [N];

    // Activations are kept non-negative after capture, so zero-extending into
    // the wider sum width preserves their value and the arithmetic shift below
    // only ever sees non-negative operands.
    always_comb begin
        w_nz_cnt  = '0;
        w_win_idx = '0;
        w_sum     = '0;
        for (int i = 0; i < N; i++) begin
            if (r_a[i] != '0) begin
                w_nz_cnt  = w_nz_cnt + NZW'(1);
                w_win_idx = IDXW'(i);
            end
            w_sum = w_sum + $signed({{(SW-W){1'b0}}, r_a[i]});
        end
        for (int i = 0; i < N; i++) begin
            w_diff[i] = $signed({{(SW-W){1'b0}}, r_a[i]})
                      - ((w_sum - $signed({{(SW-W){1'b0}}, r_a[i]})) >>> EPS_SHIFT);
            // The result is never above the old activation, so when it is
            // non-negative the low W bits hold it exactly.
            w_a_next[i] = w_diff[i][SW-1] ? '0 : w_diff[i][W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_iter     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            winner_idx <= '0;
            res        <= '0;
            for (int i = 0; i < N; i++) begin
                r_x[i] <= '0;
                r_a[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            r_x[i] <= x_in[i*W +: W];
                            r_a[i] <= x_in[i*W + W - 1] ? '0 : x_in[i*W +: W];
                        end
                        r_iter     <= '0;
                        valid      <= 1'b0;
                        timeout    <= 1'b0;
                        winner_idx <= '0;
                        res        <= '0;
                        busy       <= 1'b1;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_nz_cnt == NZW'(1)) begin
                        valid      <= 1'b1;
                        winner_idx <= w_win_idx;
                        res        <= r_x[w_win_idx];
                        r_state    <= S_DONE;
                    end else if (w_nz_cnt == '0) begin
                        valid   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_iter == IW'(MAX_ITER)) begin
                        timeout <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    for (int i = 0; i < N; i++) begin
                        r_a[i] <= w_a_next[i];
                    end
                    r_iter  <= r_iter + IW'(1);
                    r_state <= S_CHECK;
                end
                S_DONE: begin
                    // The registered pulse lands in the cycle after DONE, which
                    // places it 2+2*I edges after the start edge.
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign iter_count = r_iter;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_maxnet_winner_engine.sv
module tb_maxnet_winner_engine;
  localparam int N         = 4;
  localparam int W         = 32;
  localparam int EPS_SHIFT = 3;
  localparam int MAX_ITER  = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                          start = 1'b0;
  logic [N*W-1:0]                x_in  = '0;
  logic                          busy, done, valid, timeout;
  logic [$clog2(N)-1:0]          winner_idx;
  logic [W-1:0]                  res;
  logic [$clog2(MAX_ITER+1)-1:0] iter_count;
  logic [1:0]                    dbg_state;

  maxnet_winner_engine #(
    .N(N), .W(W), .EPS_SHIFT(EPS_SHIFT), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in),
    .busy(busy), .done(done), .valid(valid), .timeout(timeout),
    .winner_idx(winner_idx), .res(res), .iter_count(iter_count),
    .dbg_state(dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: plain integer iteration of the inhibition rule
  task automatic ref_model(input logic [N*W-1:0] x, output bit ev, output bit eto,
                           output int eidx, output logic [W-1:0] eres, output int eiter);
    longint a[N];
    longint nxt[N];
    longint s, xi;
    int nz, last;
    ev = 0; eto = 0; eidx = 0; eres = '0; eiter = 0;
    for (int i = 0; i < N; i++) begin
      xi = $signed(x[i*W +: W]);
      a[i] = (xi > 0) ? xi : 0;
    end
    while (1) begin
      nz = 0; last = 0;
      for (int i = 0; i < N; i++) if (a[i] != 0) begin nz++; last = i; end
      if (nz == 1) begin ev = 1; eidx = last; eres = x[last*W +: W]; break; end
      if (nz == 0) break;
      if (eiter == MAX_ITER) begin eto = 1; break; end
      s = 0;
      for (int i = 0; i < N; i++) s += a[i];
      for (int i = 0; i < N; i++) begin
        nxt[i] = a[i] - (s - a[i]) / (64'sd1 << EPS_SHIFT);
        if (nxt[i] < 0) nxt[i] = 0;
      end
      for (int i = 0; i < N; i++) a[i] = nxt[i];
      eiter++;
    end
  endtask

  function automatic logic [N*W-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
    logic [N*W-1:0] p;
    p[0*W +: W] = 32'(v0);
    p[1*W +: W] = 32'(v1);
    p[2*W +: W] = 32'(v2);
    p[3*W +: W] = 32'(v3);
    return p;
  endfunction

  // driver: one full run, optionally poking start while busy
  task automatic run_case(input string tag, input logic [N*W-1:0] x, input bit poke_busy);
    bit ev, eto, seen;
    int eidx, eiter, lat;
    logic [W-1:0] eres, held;
    ref_model(x, ev, eto, eidx, eres, eiter);
    exp_q.push_back(eres);
    @(negedge clk);
    x_in  = x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, ".busy"}, 64'(busy), 64'd1);
    lat = 0;
    seen = 0;
    while (!seen && lat < 400) begin
      if (poke_busy && lat == 1) begin
        start = 1'b1;
        x_in  = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (done) seen = 1;
    end
    start = 1'b0;
    check_eq({tag, ".done_seen"}, 64'(seen), 64'd1);
    held = exp_q.pop_front();
    if (seen) begin
      check_eq({tag, ".latency"}, 64'(lat), 64'(2 + 2 * eiter));
      check_eq({tag, ".valid"}, 64'(valid), 64'(ev));
      check_eq({tag, ".timeout"}, 64'(timeout), 64'(eto));
      check_eq({tag, ".winner_idx"}, 64'(winner_idx), 64'(eidx));
      check_eq({tag, ".res"}, 64'(res), 64'(held));
      check_eq({tag, ".iter_count"}, 64'(iter_count), 64'(eiter));
      check_eq({tag, ".busy_end"}, 64'(busy), 64'd0);
      @(negedge clk);
      check_eq({tag, ".done_pulse"}, 64'(done), 64'd0);
      check_eq({tag, ".valid_hold"}, 64'(valid), 64'(ev));
      check_eq({tag, ".res_hold"}, 64'(res), 64'(held));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".busy"}, 64'(busy), 64'd0);
    check_eq({tag, ".done"}, 64'(done), 64'd0);
    check_eq({tag, ".valid"}, 64'(valid), 64'd0);
    check_eq({tag, ".timeout"}, 64'(timeout), 64'd0);
    check_eq({tag, ".winner_idx"}, 64'(winner_idx), 64'd0);
    check_eq({tag, ".res"}, 64'(res), 64'd0);
    check_eq({tag, ".iter_count"}, 64'(iter_count), 64'd0);
  endtask

  initial begin
    logic [N*W-1:0] xr;
    int mode, v;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // directed cases
    run_case("c1_single", pack4(0, 50, 0, 0), 0);
    run_case("c2_two", pack4(80, 40, 0, 0), 0);
    run_case("c3_tie_timeout", pack4(16, 16, 16, 16), 0);
    run_case("c4_nonpos", pack4(-5, 0, -1, 0), 0);
    run_case("c5_poke", pack4(80, 40, 0, 0), 1);
    run_case("c5_fresh", pack4(0, 0, 0, 7), 0);
    run_case("max_pos", pack4(32'h7fffffff, 32'h7fffffff, 32'h7ffffff0, 32'h7fffffff), 0);

    // reset during the second UPDATE of case 2
    @(negedge clk);
    x_in  = pack4(80, 40, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("c6.iter_before_rst", 64'(iter_count), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("c6_after_rst");
    run_case("c6_rerun_c1", pack4(0, 50, 0, 0), 0);

    // randomized runs
    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(0, 3);
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: v = int'($urandom_range(0, 240)) - 40;
          1: v = 100 + int'($urandom_range(0, 3));
          2: v = int'($urandom);
          default: v = (i == 0) ? int'($urandom_range(500, 5000)) : int'($urandom_range(0, 60));
        endcase
        xr[i*W +: W] = 32'(v);
      end
      run_case($sformatf("rand%0d", k), xr, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
